// File: rtl/occupancy_counter.sv
// occupancy_counter: counts room occupancy in BCD from debounced enter/exit door sensors
// Ports: Clock, ResetN (sync active-low), EnterSensor/ExitSensor (raw async),
//        Clear (sync clear), PersonTens/PersonOnes (BCD count), Empty, Full, Rejected (1-cycle pulse)
module occupancy_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_PERSONS = 44
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       EnterSensor,
  input  logic       ExitSensor,
  input  logic       Clear,
  output logic [3:0] PersonTens,
  output logic [3:0] PersonOnes,
  output logic       Empty,
  output logic       Full,
  output logic       Rejected
);
  localparam logic [15:0] CNT_TOP = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MAX_T = 4'(MAX_PERSONS / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_PERSONS % 10);
  logic [1:0] raw, s1, s2, db, dbd, pulse;
  logic [15:0] cnt [2];
  logic [3:0] nxt_t, nxt_o;
  logic at_max, at_zero, en_only, ex_only, rej_nxt;
  assign raw = {ExitSensor, EnterSensor};
  assign pulse = db & ~dbd;
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      dbd <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      dbd <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_TOP) begin
          db[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end
  always_comb begin
    at_max = PersonTens == MAX_T && PersonOnes == MAX_O;
    at_zero = PersonTens == 4'd0 && PersonOnes == 4'd0;
    en_only = pulse[0] & ~pulse[1];
    ex_only = pulse[1] & ~pulse[0];
    nxt_t = Clear ? 4'd0 :
            (en_only && !at_max) ? (PersonOnes == 4'd9 ? PersonTens + 4'd1 : PersonTens) :
            (ex_only && !at_zero) ? (PersonOnes == 4'd0 ? PersonTens - 4'd1 : PersonTens) :
            PersonTens;
    nxt_o = Clear ? 4'd0 :
            (en_only && !at_max) ? (PersonOnes == 4'd9 ? 4'd0 : PersonOnes + 4'd1) :
            (ex_only && !at_zero) ? (PersonOnes == 4'd0 ? 4'd9 : PersonOnes - 4'd1) :
            PersonOnes;
    rej_nxt = !Clear && ((en_only && at_max) || (ex_only && at_zero));
  end
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      PersonTens <= '0;
      PersonOnes <= '0;
      Empty <= 1'b1;
      Full <= 1'b0;
      Rejected <= 1'b0;
    end else begin
      PersonTens <= nxt_t;
      PersonOnes <= nxt_o;
      Empty <= nxt_t == 4'd0 && nxt_o == 4'd0;
      Full <= nxt_t == MAX_T && nxt_o == MAX_O;
      Rejected <= rej_nxt;
    end
  end
endmodule

// File: tb/tb_occupancy_counter.sv
// tb_occupancy_counter: table, directed and random checks of occupancy_counter against a window-based model
module tb_occupancy_counter;
  localparam int D = 4;
  localparam int MAXP = 44;
  logic Clock = 1'b0, ResetN = 1'b0, EnterSensor = 1'b0, ExitSensor = 1'b0, Clear = 1'b0;
  logic [3:0] PersonTens, PersonOnes;
  logic Empty, Full, Rejected;
  int n_cmp = 0, n_bad = 0, rej_seen = 0, cyc = 0;
  int m_cnt = 0;
  bit m_rej = 0;
  bit m_s1 [2], m_s2 [2], m_db [2], m_dbd [2];
  bit hist [2][$];
  typedef struct {
    bit rn, en;
    int t, o, e, f, r;
  } vec_t;
  vec_t tbl [12];

  occupancy_counter #(.DEBOUNCE_CYCLES(D), .MAX_PERSONS(MAXP)) dut (
    .Clock(Clock), .ResetN(ResetN), .EnterSensor(EnterSensor), .ExitSensor(ExitSensor),
    .Clear(Clear), .PersonTens(PersonTens), .PersonOnes(PersonOnes),
    .Empty(Empty), .Full(Full), .Rejected(Rejected)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Model: a sensor's debounced level flips once its last D synchronized samples all disagree with it.
  task automatic model_edge(input bit en, input bit ex, input bit clr, input bit rn);
    bit pe, px, all_diff;
    bit raw [2];
    raw[0] = en;
    raw[1] = ex;
    if (!rn) begin
      m_cnt = 0;
      m_rej = 0;
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbd[i] = 0;
        hist[i].delete();
      end
      return;
    end
    pe = m_db[0] && !m_dbd[0];
    px = m_db[1] && !m_dbd[1];
    m_rej = 0;
    if (clr) m_cnt = 0;
    else if (pe && !px) begin
      if (m_cnt < MAXP) m_cnt++; else m_rej = 1;
    end else if (px && !pe) begin
      if (m_cnt > 0) m_cnt--; else m_rej = 1;
    end
    for (int i = 0; i < 2; i++) begin
      m_dbd[i] = m_db[i];
      hist[i].push_back(m_s2[i]);
      if (hist[i].size() > D) void'(hist[i].pop_front());
      all_diff = hist[i].size() == D;
      foreach (hist[i][k]) if (hist[i][k] == m_db[i]) all_diff = 0;
      if (all_diff) m_db[i] = !m_db[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  task automatic step(input bit en, input bit ex, input bit clr, input bit rn);
    EnterSensor = en;
    ExitSensor = ex;
    Clear = clr;
    ResetN = rn;
    @(posedge Clock);
    model_edge(en, ex, clr, rn);
    #1;
    cyc++;
    if (Rejected) rej_seen++;
    check("model_state", {PersonTens, PersonOnes, Empty, Full, Rejected},
          {4'(m_cnt / 10), 4'(m_cnt % 10), m_cnt == 0, m_cnt == MAXP, m_rej});
  endtask

  task automatic press(input bit en, input bit ex);
    repeat (6) step(en, ex, 0, 1);
    repeat (8) step(0, 0, 0, 1);
  endtask

  task automatic expect_count(input string name, input int n);
    check(name, PersonTens * 10 + PersonOnes, n);
  endtask

  initial begin
    bit ren = 0, rex = 0;
    for (int k = 0; k < 12; k++) begin
      tbl[k].rn = k >= 2;
      tbl[k].en = k >= 2;
      tbl[k].t = 0;
      tbl[k].o = k >= 8 ? 1 : 0;
      tbl[k].e = k >= 8 ? 0 : 1;
      tbl[k].f = 0;
      tbl[k].r = 0;
    end
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].en, 0, 0, tbl[k].rn);
      check("tbl_tens", PersonTens, tbl[k].t);
      check("tbl_ones", PersonOnes, tbl[k].o);
      check("tbl_empty", Empty, tbl[k].e);
      check("tbl_full", Full, tbl[k].f);
      check("tbl_rej", Rejected, tbl[k].r);
    end
    repeat (8) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    rej_seen = 0;
    repeat (2) begin
      repeat (2) step(1, 0, 0, 1);
      repeat (2) step(0, 0, 0, 1);
    end
    repeat (10) step(0, 0, 0, 1);
    expect_count("bounce_count", 0);
    check("bounce_rej", rej_seen, 0);
    repeat (10) press(1, 0);
    expect_count("wrap_up", 10);
    press(0, 1);
    expect_count("wrap_down", 9);
    step(0, 0, 1, 1);
    repeat (MAXP) press(1, 0);
    expect_count("to_max", MAXP);
    check("full_at_max", Full, 1);
    rej_seen = 0;
    press(1, 0);
    expect_count("sat_max", MAXP);
    check("rej_max", rej_seen, 1);
    step(0, 0, 1, 1);
    rej_seen = 0;
    press(0, 1);
    expect_count("sat_zero", 0);
    check("rej_zero", rej_seen, 1);
    repeat (12) press(1, 0);
    rej_seen = 0;
    press(1, 1);
    expect_count("both", 12);
    check("both_rej", rej_seen, 0);
    repeat (6) step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    expect_count("clear_pulse", 0);
    check("clear_empty", Empty, 1);
    repeat (10) step(0, 0, 0, 1);
    expect_count("clear_after", 0);
    check("clear_rej", rej_seen, 0);
    repeat (23) press(1, 0);
    expect_count("at_23", 23);
    repeat (4) step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    repeat (15) step(0, 0, 0, 1);
    expect_count("rst_low_rel", 0);
    check("rst_low_rej", rej_seen, 0);
    repeat (4) step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    repeat (12) step(0, 1, 0, 1);
    repeat (8) step(0, 0, 0, 1);
    expect_count("rst_high_rel", 0);
    check("rst_high_rej", rej_seen, 1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) ren = !ren;
      if ($urandom_range(6) == 0) rex = !rex;
      step(ren, rex, $urandom_range(80) == 0, $urandom_range(400) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
- Counts people in the room from two door sensors, Enter and Exit.
- Drives the BCD occupancy digits PersonTens/PersonOnes that the optimum-temperature lookup and the display consume.
- Each raw sensor passes through a synchronizer, a debouncer and a rising-edge detector.
- The count is kept directly in BCD and saturates at 0 and at MAX_PERSONS.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before a sensor level change is accepted. Legal range 1..65535.
- MAX_PERSONS, 44: highest legal occupancy, which is the top of the temperature table. Legal range 1..99.

Ports:
- Clock  input  1  system clock; all logic on the rising edge.
- ResetN  input  1  synchronous, active-low reset.
- EnterSensor  input  1  raw entry sensor, asynchronous, may bounce.
- ExitSensor  input  1  raw exit sensor, asynchronous, may bounce.
- Clear  input  1  synchronous occupancy clear, active-high.
- PersonTens  output  4  BCD tens digit of occupancy.
- PersonOnes  output  4  BCD ones digit of occupancy.
- Empty  output  1  high when occupancy == 0.
- Full  output  1  high when occupancy == MAX_PERSONS.
- Rejected  output  1  one-cycle pulse when an event is discarded by saturation.

Behaviour:
- Reset (ResetN=0 at a rising edge) clears everything in the same edge:
  - sync flops, debounce counters, debounced levels and delayed levels = 0;
  - PersonTens = 0, PersonOnes = 0, Empty = 1, Full = 0, Rejected = 0.
- Synchronizer: two flops per sensor; the output is S.
- Debouncer, per sensor, with debounced level DB and counter CNT:
  - S == DB: CNT <= 0.
  - S != DB and CNT < DEBOUNCE_CYCLES-1: CNT <= CNT+1.
  - S != DB and CNT == DEBOUNCE_CYCLES-1: DB <= S, CNT <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes DB.
- Edge detect: DBD <= DB each cycle; Pulse = DB & ~DBD. Only rising edges count; falling edges are ignored.
- Latency: with the raw input held high from before edge 1, the count changes at edge DEBOUNCE_CYCLES+3 (edge 7 for the default).
- A sensor already high when reset is released is treated as a new rising edge and counts after the same latency.
- Count update each cycle, highest priority first:
  1. Clear = 1: count <= 0; any Pulse in this cycle is discarded with no Rejected.
  2. EnterPulse and ExitPulse both = 1: no change, no Rejected.
  3. EnterPulse only:
     - count < MAX_PERSONS: BCD increment (ones 9 -> 0 with tens+1, else ones+1).
     - count == MAX_PERSONS: no change, Rejected = 1 for one cycle.
  4. ExitPulse only:
     - count > 0: BCD decrement (ones 0 -> 9 with tens-1, else ones-1).
     - count == 0: no change, Rejected = 1 for one cycle.
- Rejected is registered: it is high for the cycle after the rejecting edge and low otherwise.
- Empty and Full are registered, derived from the next-count value, so they are always consistent with PersonTens/PersonOnes.
- Digits are always valid BCD (each 0..9). A non-BCD state is unreachable; no recovery is required.
- Clear does not affect the synchronizers or debouncers.
- Reset asserted mid-debounce discards the pending change.

Test Plan:
1. Reset with ResetN=0 for 2 cycles, sensors 0 -> digits 0/0, Empty=1, Full=0, Rejected=0. Then hold EnterSensor=1 for 10 cycles -> count becomes 0/1 exactly at edge 7 after the first high sample, Empty falls at the same edge.
2. Bounce EnterSensor 1-0-1-0 with 2-cycle highs (DEBOUNCE_CYCLES=4) -> count unchanged at 0/0, Rejected never asserted.
3. Apply 10 clean enter presses from 0 -> ones wraps 9 -> 0, tens becomes 1 (1/0). Then one exit press -> 0/9.
4. Enter up to 44 -> Full=1 at 4/4. One more enter -> count stays 4/4, one Rejected pulse. At 0, one exit -> stays 0/0, one Rejected pulse.
5. At 1/2, align EnterSensor and ExitSensor so both pulses occur in the same cycle -> count stays 1/2, no Rejected. Separately, Clear asserted in the same cycle as an EnterPulse -> 0/0, Empty=1, no Rejected.
6. At 2/3, pull ResetN low mid-debounce of an ExitSensor press, then release with ExitSensor low -> 0/0, no later decrement. Release with ExitSensor still high -> count 0 stays 0 and Rejected pulses once after latency.
